// File: rtl/gb_video_pkg.sv
// Shared video types and constants for the DMG-style LCD path.
// The palette helpers are only used when SCANOUT_PALETTE_EN is defined.
package gb_video_pkg;

  localparam int LCD_WIDTH   = 160;
  localparam int LCD_HEIGHT  = 144;
  localparam int VBUF_ADDR_W = 15;
  localparam int SHADE_W     = 2;

  typedef logic [SHADE_W-1:0] shade_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } scanout_state_t;

  localparam logic [23:0] DMG_GRAY_0 = 24'hFFFFFF;
  localparam logic [23:0] DMG_GRAY_1 = 24'hAAAAAA;
  localparam logic [23:0] DMG_GRAY_2 = 24'h555555;
  localparam logic [23:0] DMG_GRAY_3 = 24'h000000;

  // One FIFO entry: frame/line markers travel with the shade they belong to.
  typedef struct packed {
    logic        sof;
    logic        eol;
    shade_t      shade;
`ifdef SCANOUT_PALETTE_EN
    logic [23:0] rgb;
`endif
  } scan_entry_t;

  // bgp packs four 2-bit gray levels; shade s selects bits [2s+1:2s].
  function automatic shade_t bgp_lookup(input logic [7:0] bgp, input shade_t s);
    logic [7:0] shifted;
    shifted = bgp >> (2 * s);
    return shifted[1:0];
  endfunction

  function automatic logic [23:0] dmg_gray(input shade_t level);
    logic [23:0] rgb;
    case (level)
      2'd0:    rgb = DMG_GRAY_0;
      2'd1:    rgb = DMG_GRAY_1;
      2'd2:    rgb = DMG_GRAY_2;
      default: rgb = DMG_GRAY_3;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/scanout_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; a push and a pop
// in the same cycle are both honoured, including when the FIFO is full.
module scanout_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full;
  logic             do_pop;

  assign empty  = (count_reg == '0);
  assign full   = (count_reg == CNT_W'(FIFO_DEPTH));
  assign do_pop = pop & ~empty;
  assign count  = count_reg;
  assign head   = mem[rd_ptr_reg];

  // Storage carries no reset; validity is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      assert (!(push && full && !do_pop));
      assert (!(pop && empty));
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/video_buffer_scanout.sv
// Reads one frame from video buffer port B in raster order and streams it out
// with credit-based prefetch. Define SCANOUT_PALETTE_EN to add bgp/pix_rgb.
module video_buffer_scanout
  import gb_video_pkg::*;
#(
  parameter int H_RES      = LCD_WIDTH,
  parameter int V_RES      = LCD_HEIGHT,
  parameter int FIFO_DEPTH = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  output logic [VBUF_ADDR_W-1:0] rd_addr,
  output logic                   rd_en,
  input  logic [SHADE_W-1:0]     rd_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [SHADE_W-1:0]     pix_data,
  output logic                   pix_sof,
  output logic                   pix_eol,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_overrun
`ifdef SCANOUT_PALETTE_EN
  ,
  input  logic [7:0]             bgp,
  output logic [23:0]            pix_rgb
`endif
);

  localparam int X_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [VBUF_ADDR_W-1:0] BASE   = VBUF_ADDR_W'(BASE_ADDR);
  localparam logic [X_W-1:0]         X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]         Y_LAST = Y_W'(V_RES - 1);

  scanout_state_t         state_reg;
  logic [X_W-1:0]         x_reg;
  logic [Y_W-1:0]         y_reg;
  logic [VBUF_ADDR_W-1:0] addr_reg;
  logic                   inflight_reg;
  logic                   tag_sof_reg;
  logic                   tag_eol_reg;
  logic                   done_reg;
  logic                   overrun_reg;
`ifdef SCANOUT_PALETTE_EN
  logic [7:0]             bgp_reg;
`endif

  scan_entry_t            push_entry;
  scan_entry_t            head_entry;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;

  logic                   pop;
  logic                   x_last;
  logic                   y_last;
  logic                   last_read;
  logic                   last_pop;
  logic [OCC_W-1:0]       occupancy;

  assign pop    = pix_valid & pix_ready;
  assign x_last = (x_reg == X_LAST);
  assign y_last = (y_reg == Y_LAST);

  // Slots already spoken for after this cycle: stored + arriving - leaving.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight_reg) - OCC_W'(pop);
  assign rd_en     = (state_reg == FETCH) && (occupancy < OCC_W'(FIFO_DEPTH));
  assign last_read = rd_en && x_last && y_last;

  // In DRAIN no reads remain, so a lone entry with nothing in flight is the last pixel.
  assign last_pop = pop && (state_reg == DRAIN) && (fifo_count == CNT_W'(1)) && !inflight_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      addr_reg     <= BASE;
      inflight_reg <= 1'b0;
      tag_sof_reg  <= 1'b0;
      tag_eol_reg  <= 1'b0;
      done_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
`ifdef SCANOUT_PALETTE_EN
      bgp_reg      <= '0;
`endif
    end else begin
      done_reg     <= 1'b0;
      overrun_reg  <= frame_start && (state_reg != IDLE);
      inflight_reg <= rd_en;
      tag_sof_reg  <= rd_en && (x_reg == '0) && (y_reg == '0);
      tag_eol_reg  <= rd_en && x_last;

      case (state_reg)
        IDLE: begin
          if (frame_start) begin
            state_reg <= FETCH;
            x_reg     <= '0;
            y_reg     <= '0;
            addr_reg  <= BASE;
`ifdef SCANOUT_PALETTE_EN
            bgp_reg   <= bgp;
`endif
          end
        end

        FETCH: begin
          if (rd_en) begin
            if (x_last) begin
              x_reg <= '0;
              if (y_last) begin
                y_reg     <= '0;
                state_reg <= DRAIN;
              end else begin
                y_reg <= y_reg + Y_W'(1);
              end
            end else begin
              x_reg <= x_reg + X_W'(1);
            end
            addr_reg <= last_read ? BASE : addr_reg + VBUF_ADDR_W'(1);
          end
        end

        DRAIN: begin
          if (last_pop) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.sof   = tag_sof_reg;
    push_entry.eol   = tag_eol_reg;
    push_entry.shade = rd_data;
`ifdef SCANOUT_PALETTE_EN
    push_entry.rgb   = dmg_gray(bgp_lookup(bgp_reg, rd_data));
`endif
  end

  scanout_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      ($bits(scan_entry_t)),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight_reg),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Head fields are forced to zero when empty so stale storage never leaks out.
  assign pix_valid     = !fifo_empty;
  assign pix_data      = pix_valid ? head_entry.shade : '0;
  assign pix_sof       = pix_valid & head_entry.sof;
  assign pix_eol       = pix_valid & head_entry.eol;
`ifdef SCANOUT_PALETTE_EN
  assign pix_rgb       = pix_valid ? head_entry.rgb : '0;
`endif

  assign rd_addr       = addr_reg;
  assign busy          = (state_reg != IDLE);
  assign frame_done    = done_reg;
  assign frame_overrun = overrun_reg;

endmodule

// File: tb/tb_video_buffer_scanout.sv
// Scoreboard bench for video_buffer_scanout: a raster reference model fills the
// expected queue at frame_start and a negedge monitor checks every handshake.
`timescale 1ns/1ps
module tb_video_buffer_scanout;

  localparam int H     = 160;
  localparam int V     = 144;
  localparam int N     = H * V;
  localparam int DEPTH = 4;

  typedef struct {
    logic       sof;
    logic       eol;
    logic [1:0] shade;
    logic [23:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_ready = 1'b0;
  logic [14:0] rd_addr;
  logic        rd_en;
  logic [1:0]  rd_data;
  logic        pix_valid;
  logic [1:0]  pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        busy;
  logic        frame_done;
  logic        frame_overrun;
`ifdef SCANOUT_PALETTE_EN
  logic [7:0]  bgp = 8'h00;
  logic [23:0] pix_rgb;
  logic [23:0] gray_tab [4];
`endif

  logic [1:0]  vram [32768];
  exp_t        sb [$];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_mode = 0;
  int reads_total = 0;
  int pops_total = 0;
  int done_total = 0;
  int overrun_total = 0;
  int done_cyc = 0;
  int rise_cyc = 0;
  int vrise_cyc = 0;
  int outstanding = 0;
  int addr_exp = 0;
  logic       prev_busy = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_word = '0;

  video_buffer_scanout dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_start   (frame_start),
    .rd_addr       (rd_addr),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .pix_data      (pix_data),
    .pix_sof       (pix_sof),
    .pix_eol       (pix_eol),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun)
`ifdef SCANOUT_PALETTE_EN
    ,
    .bgp           (bgp),
    .pix_rgb       (pix_rgb)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer port B model: data appears the cycle after the enable.
  always @(posedge clk) if (rd_en) rd_data <= vram[rd_addr];

  // Downstream acceptance pattern, changed just after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       pix_ready = 1'b0;
        1:       pix_ready = 1'b1;
        default: pix_ready = 1'($urandom_range(1));
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: owns all handshake bookkeeping and the scoreboard pops.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_busy   = 1'b0;
      prev_valid  = 1'b0;
      prev_stall  = 1'b0;
      outstanding = 0;
      addr_exp    = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(pix_valid), 32'd1);
        check("stall_word", 32'({pix_sof, pix_eol, pix_data}), 32'(prev_word));
      end
      if (rd_en) begin
        reads_total++;
        check("rd_en_only_when_busy", 32'(busy), 32'd1);
        check("rd_addr_raster", 32'(rd_addr), 32'(addr_exp));
        addr_exp = (addr_exp == N - 1) ? 0 : addr_exp + 1;
      end
      if (pix_valid && pix_ready) begin
        pops_total++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra_pixel: got shade %0d, expected no pixel (cycle %0d)", pix_data, cyc);
        end else begin
          e = sb.pop_front();
          check("pix_data", 32'(pix_data), 32'(e.shade));
          check("pix_sof", 32'(pix_sof), 32'(e.sof));
          check("pix_eol", 32'(pix_eol), 32'(e.eol));
`ifdef SCANOUT_PALETTE_EN
          check("pix_rgb", 32'(pix_rgb), 32'(e.rgb));
`endif
        end
      end
      outstanding = outstanding + (rd_en ? 1 : 0) - ((pix_valid && pix_ready) ? 1 : 0);
      check("credit_limit", 32'(outstanding <= DEPTH), 32'd1);
      if (frame_done) begin
        done_total++;
        done_cyc = cyc;
        check("done_with_empty_sb", 32'(sb.size()), 32'd0);
      end
      if (frame_overrun) overrun_total++;
      if (busy && !prev_busy) rise_cyc = cyc;
      if (pix_valid && !prev_valid) vrise_cyc = cyc;
      prev_busy  = busy;
      prev_valid = pix_valid;
      prev_stall = pix_valid && !pix_ready;
      prev_word  = {pix_sof, pix_eol, pix_data};
    end
  end

  // Reference model: raster walk of the buffer, markers from x/y position.
  task automatic start_frame();
    exp_t e;
    int   addr;
`ifdef SCANOUT_PALETTE_EN
    logic [7:0] sh;
`endif
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        addr    = y * H + x;
        e.shade = vram[addr];
        e.sof   = (x == 0) && (y == 0);
        e.eol   = (x == H - 1);
        e.rgb   = '0;
`ifdef SCANOUT_PALETTE_EN
        sh      = bgp >> (2 * e.shade);
        e.rgb   = gray_tab[sh[1:0]];
`endif
        sb.push_back(e);
      end
    end
    pulse_start();
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n = 0;
    while (pops_total < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (pops_total < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL pops_timeout: got %0d pixels, expected %0d", pops_total, target);
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_total < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_total < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got %0d frame_done pulses, expected %0d", done_total, target);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32768; i++) vram[i] = 2'($urandom);
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0, o0, r0;
`ifdef SCANOUT_PALETTE_EN
    gray_tab[0] = 24'hFFFFFF;
    gray_tab[1] = 24'hAAAAAA;
    gray_tab[2] = 24'h555555;
    gray_tab[3] = 24'h000000;
`endif
    for (int i = 0; i < 32768; i++) vram[i] = 2'(i % 4);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_addr", 32'(rd_addr), 32'd0);
    check("reset_rd_en", 32'(rd_en), 32'd0);
    check("reset_pix_valid", 32'(pix_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_overrun", 32'(frame_overrun), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Frame 1: full rate, shade = addr mod 4, frame_start on the last handshake
    p0 = pops_total; d0 = done_total; o0 = overrun_total; r0 = reads_total;
`ifdef SCANOUT_PALETTE_EN
    bgp = 8'hE4;
`endif
    ready_mode = 1;
    start_frame();
    wait_pops(p0 + 100, 500);
`ifdef SCANOUT_PALETTE_EN
    @(posedge clk);
    #1 bgp = 8'h1B;
`endif
    while (cyc < rise_cyc + N + 1) begin
      @(posedge clk);
      #1;
    end
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    wait_done(d0 + 1, 1000);
    check("f1_busy_low_at_done", 32'(busy), 32'd0);
    check("f1_frame_length", 32'(done_cyc - rise_cyc), 32'(N + 2));
    check("f1_first_valid_latency", 32'(vrise_cyc - rise_cyc), 32'd2);
    check("f1_pixel_count", 32'(pops_total - p0), 32'(N));
    repeat (20) @(negedge clk);
    #1;
    check("f1_overrun_on_last_handshake", 32'(overrun_total - o0), 32'd1);
    check("f1_no_second_frame", 32'(busy), 32'd0);
    check("f1_read_count", 32'(reads_total - r0), 32'(N));
    check("f1_done_once", 32'(done_total - d0), 32'd1);

    // Frame 2: stalled start, then 50% ready, overrun request at pixel 5000
    fill_random();
    p0 = pops_total; d0 = done_total; o0 = overrun_total; r0 = reads_total;
`ifdef SCANOUT_PALETTE_EN
    bgp = 8'h1B;
`endif
    ready_mode = 0;
    start_frame();
    repeat (100) @(negedge clk);
    #1;
    check("f2_prefetch_reads", 32'(reads_total - r0), 32'(DEPTH));
    check("f2_rd_en_held_off", 32'(rd_en), 32'd0);
    ready_mode = 2;
    wait_pops(p0 + 5000, 20000);
    pulse_start();
    repeat (3) @(negedge clk);
    #1;
    check("f2_overrun_pulse", 32'(overrun_total - o0), 32'd1);
    ready_mode = 1;
    wait_done(d0 + 1, 40000);
    check("f2_pixel_count", 32'(pops_total - p0), 32'(N));
    repeat (20) @(negedge clk);
    #1;
    check("f2_no_second_frame", 32'(busy), 32'd0);
    check("f2_read_count", 32'(reads_total - r0), 32'(N));
    check("f2_done_once", 32'(done_total - d0), 32'd1);

    // Frame 3: reset asserted mid-frame
    fill_random();
    p0 = pops_total; d0 = done_total; o0 = overrun_total;
`ifdef SCANOUT_PALETTE_EN
    bgp = 8'($urandom);
`endif
    start_frame();
    wait_pops(p0 + 10000, 20000);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_rd_en", 32'(rd_en), 32'd0);
    check("abort_rd_addr", 32'(rd_addr), 32'd0);
    check("abort_pix_valid", 32'(pix_valid), 32'd0);
    check("abort_pix_data", 32'(pix_data), 32'd0);
    check("abort_pix_sof_eol", 32'({pix_sof, pix_eol}), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pulses", 32'({frame_done, frame_overrun}), 32'd0);
`ifdef SCANOUT_PALETTE_EN
    check("abort_pix_rgb", 32'(pix_rgb), 32'd0);
`endif
    sb.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    r0 = reads_total;
    repeat (10) @(negedge clk);
    #1;
    check("post_reset_idle", 32'(busy), 32'd0);
    check("post_reset_no_reads", 32'(reads_total - r0), 32'd0);
    check("post_reset_no_pulses", 32'((done_total - d0) + (overrun_total - o0)), 32'd0);

    // Frame 4: restart after reset from address 0 with random backpressure
    fill_random();
    p0 = pops_total;
`ifdef SCANOUT_PALETTE_EN
    bgp = 8'($urandom);
`endif
    ready_mode = 2;
    start_frame();
    wait_pops(p0 + 1500, 6000);
    check("f4_busy_mid_frame", 32'(busy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
